// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and its datapath plus unified memory.
// The master side is the sequencer; the slave side is the datapath/memory.
interface multicycle_ctrl_if;
  logic [5:0] op_code;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_not;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       sign;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       jal;
  logic       illegal;
  logic       bus_error;
  logic [3:0] state;

  modport master (
    input  op_code, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_not, pc_src,
           alu_src_a, alu_src_b, alu_op, sign, reg_write, reg_dst, mem_to_reg, jal,
           illegal, bus_error, state
  );

  modport slave (
    output op_code, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_not, pc_src,
           alu_src_a, alu_src_b, alu_op, sign, reg_write, reg_dst, mem_to_reg, jal,
           illegal, bus_error, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB over a shared ALU
// and a unified memory with req/ready handshake and a per-access wait timeout.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10, ERROR  = 4'd15
  } stateT;

  typedef struct packed {
    logic       memReq;
    logic       memWe;
    logic       iord;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       branchNot;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [3:0] aluOp;
    logic       sign;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       jal;
    logic       busError;
  } ctrlT;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  stateT         stateR;
  stateT         nextState;
  ctrlT          ctrlR;
  logic [CW-1:0] waitCntR;
  logic          memWait;
  logic          timeout;
  logic          legalOp;
  logic          fetchDone;
  logic          unusedZero;

  function automatic logic isLegal(input logic [5:0] op);
    return op inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
                      OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW};
  endfunction

  // Control word presented while sitting in state st with the current instruction op.
  function automatic ctrlT mooreOut(input stateT st, input logic [5:0] op);
    ctrlT o;
    o = '0;
    case (st)
      FETCH: begin
        o.memReq  = 1'b1;
        o.aluSrcB = 2'b01;
        o.aluOp   = 4'b0011;
      end
      DECODE: begin
        o.aluSrcB = 2'b11;
        o.aluOp   = 4'b0011;
        o.sign    = 1'b1;
      end
      MEMADR: begin
        o.aluSrcA = 1'b1;
        o.aluSrcB = 2'b10;
        o.sign    = 1'b1;
        o.aluOp   = (op == OP_SW) ? 4'b1011 : 4'b0011;
      end
      MEMRD: begin
        o.memReq = 1'b1;
        o.iord   = 1'b1;
      end
      MEMWB: begin
        o.regWrite = 1'b1;
        o.memToReg = 1'b1;
      end
      MEMWR: begin
        o.memReq = 1'b1;
        o.memWe  = 1'b1;
        o.iord   = 1'b1;
      end
      EXEC: begin
        o.aluSrcA = 1'b1;
        o.aluSrcB = (op == OP_R) ? 2'b00 : 2'b10;
        case (op)
          OP_R:     o.aluOp = 4'b0010;
          OP_ADDI:  begin o.aluOp = 4'b1000; o.sign = 1'b1; end
          OP_ADDIU: o.aluOp = 4'b1001;
          OP_ANDI:  o.aluOp = 4'b1100;
          OP_ORI:   o.aluOp = 4'b1101;
          OP_XORI:  o.aluOp = 4'b1110;
          OP_SLTI:  begin o.aluOp = 4'b1010; o.sign = 1'b1; end
          OP_SLTIU: o.aluOp = 4'b0001;
          OP_LUI:   o.aluOp = 4'b1111;
          default:  o.aluOp = 4'b0000;
        endcase
      end
      ALUWB: begin
        o.regWrite = 1'b1;
        o.regDst   = (op == OP_R);
      end
      BRANCH: begin
        o.aluSrcA     = 1'b1;
        o.aluOp       = 4'b0100;
        o.pcWriteCond = 1'b1;
        o.pcSrc       = 2'b01;
        o.branchNot   = (op == OP_BNE);
      end
      JUMP: begin
        o.pcWrite  = 1'b1;
        o.pcSrc    = 2'b10;
        o.regWrite = (op == OP_JAL);
        o.jal      = (op == OP_JAL);
      end
      ERROR:   o.busError = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // zero only gates the PC enable inside the datapath; the sequencer never branches on it.
  assign unusedZero = bus.zero;

  assign legalOp   = isLegal(bus.op_code);
  assign memWait   = stateR inside {FETCH, MEMRD, MEMWR};
  assign fetchDone = (stateR == FETCH) && bus.mem_ready;
  // A ready arriving in the last allowed wait cycle still completes the access.
  assign timeout   = (MEM_TIMEOUT != 0) && memWait && !bus.mem_ready &&
                     (waitCntR == CW'(MEM_TIMEOUT - 1));

  // Next-state selection.
  always_comb begin
    nextState = stateR;
    case (stateR)
      IDLE:   nextState = FETCH;
      FETCH:  begin
        if (bus.mem_ready)  nextState = DECODE;
        else if (timeout)   nextState = ERROR;
        else                nextState = FETCH;
      end
      DECODE: begin
        if (!legalOp)                                  nextState = FETCH;
        else if (bus.op_code inside {OP_LW, OP_SW})    nextState = MEMADR;
        else if (bus.op_code inside {OP_BEQ, OP_BNE})  nextState = BRANCH;
        else if (bus.op_code inside {OP_J, OP_JAL})    nextState = JUMP;
        else                                           nextState = EXEC;
      end
      MEMADR: nextState = (bus.op_code == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  begin
        if (bus.mem_ready)  nextState = MEMWB;
        else if (timeout)   nextState = ERROR;
        else                nextState = MEMRD;
      end
      MEMWR:  begin
        if (bus.mem_ready)  nextState = FETCH;
        else if (timeout)   nextState = ERROR;
        else                nextState = MEMWR;
      end
      EXEC:   nextState = ALUWB;
      MEMWB, ALUWB, BRANCH, JUMP: nextState = FETCH;
      ERROR:  nextState = ERROR;
      default: nextState = ERROR;
    endcase
  end

  // State register and the registered control word of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR <= IDLE;
      ctrlR  <= '0;
    end else begin
      stateR <= nextState;
      ctrlR  <= mooreOut(nextState, bus.op_code);
    end
  end

  // Memory wait counter: restarts on every state change and on each completed access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCntR <= '0;
    end else if ((nextState != stateR) || bus.mem_ready) begin
      waitCntR <= '0;
    end else if (memWait) begin
      waitCntR <= waitCntR + CW'(1);
    end else begin
      waitCntR <= waitCntR;
    end
  end

  assign bus.mem_req       = ctrlR.memReq;
  assign bus.mem_we        = ctrlR.memWe;
  assign bus.iord          = ctrlR.iord;
  assign bus.ir_write      = fetchDone;
  assign bus.pc_write      = ctrlR.pcWrite || fetchDone;
  assign bus.pc_write_cond = ctrlR.pcWriteCond;
  assign bus.branch_not    = ctrlR.branchNot;
  assign bus.pc_src        = ctrlR.pcSrc;
  assign bus.alu_src_a     = ctrlR.aluSrcA;
  assign bus.alu_src_b     = ctrlR.aluSrcB;
  assign bus.alu_op        = ctrlR.aluOp;
  assign bus.sign          = ctrlR.sign;
  assign bus.reg_write     = ctrlR.regWrite;
  assign bus.reg_dst       = ctrlR.regDst;
  assign bus.mem_to_reg    = ctrlR.memToReg;
  assign bus.jal           = ctrlR.jal;
  assign bus.illegal       = (stateR == DECODE) && !legalOp;
  assign bus.bus_error     = ctrlR.busError;
  assign bus.state         = stateR;

endmodule
